// File: rtl/cla_pipe_adder_if.sv
// Operand/result bundle for the pipelined CLA adder.
// master drives operands and out_ready; slave is the adder itself.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead add/subtract, one GROUP-bit look-ahead group per stage.
// Latency WIDTH/GROUP cycles, throughput one op per cycle.
// Backpressure: single global stall; in_ready = out_ready | ~out_valid.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  io
);
  localparam int NUM_GROUPS = WIDTH / GROUP;

  if (GROUP < 1) begin : g_bad_group
    $error("cla_pipe_adder: GROUP must be >= 1");
  end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  // Every carry is a flat sum-of-products of g/p and the group carry-in.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             c);
    logic [GROUP:0] cy;
    logic           t;
    cy    = '0;
    cy[0] = c;
    for (int i = 0; i < GROUP; i++) begin
      t = c;
      for (int m = 0; m <= i; m++) t = t & p[m];
      cy[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        cy[i+1] = cy[i+1] | t;
      end
    end
    return cy;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  assign adv         = io.out_ready | ~io.out_valid;
  assign io.in_ready = adv;
  assign bx          = io.sub ? ~io.b : io.b;
  assign c0          = io.sub | io.cin;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_st
    localparam int LO = k * GROUP;
    localparam int HI = LO + GROUP - 1;

    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic             ci;
    logic             vi;
    logic [GROUP:0]   gc;
    logic [GROUP-1:0] gs;
    logic [HI:0]      nsum;
    logic             r_vld;
    logic             r_c;
    logic [HI:0]      r_sum;

    if (k == 0) begin : g_src
      assign ga   = io.a[HI:0];
      assign gb   = bx[HI:0];
      assign ci   = c0;
      assign vi   = io.in_valid;
      assign nsum = gs;
    end else begin : g_src
      assign ga   = g_st[k-1].g_op.r_a[HI:LO];
      assign gb   = g_st[k-1].g_op.r_b[HI:LO];
      assign ci   = g_st[k-1].r_c;
      assign vi   = g_st[k-1].r_vld;
      assign nsum = {gs, g_st[k-1].r_sum};
    end

    assign gc = cla_carries(ga & gb, ga ^ gb, ci);
    assign gs = (ga ^ gb) ^ gc[GROUP-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (adv) begin
        r_vld <= vi;
        r_c   <= gc[GROUP];
        r_sum <= nsum;
      end
    end

    // Operand groups not yet consumed ride along, skewed one stage per group.
    if (k < NUM_GROUPS - 1) begin : g_op
      logic [WIDTH-1:HI+1] na;
      logic [WIDTH-1:HI+1] nb;
      logic [WIDTH-1:HI+1] r_a;
      logic [WIDTH-1:HI+1] r_b;

      if (k == 0) begin : g_fwd
        assign na = io.a[WIDTH-1:HI+1];
        assign nb = bx[WIDTH-1:HI+1];
      end else begin : g_fwd
        assign na = g_st[k-1].g_op.r_a[WIDTH-1:HI+1];
        assign nb = g_st[k-1].g_op.r_b[WIDTH-1:HI+1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (adv) begin
          r_a <= na;
          r_b <= nb;
        end
      end
    end

    if (k == NUM_GROUPS - 1) begin : g_msb
      logic r_cm;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cm <= 1'b0;
        end else if (adv) begin
          r_cm <= gc[GROUP-1];
        end
      end
    end
  end

  assign io.out_valid = g_st[NUM_GROUPS-1].r_vld;
  assign io.sum       = g_st[NUM_GROUPS-1].r_sum;
  assign io.cout      = g_st[NUM_GROUPS-1].r_c;
  assign io.ovf       = g_st[NUM_GROUPS-1].r_c ^ g_st[NUM_GROUPS-1].g_msb.r_cm;
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor.
- Splits a WIDTH-bit add into WIDTH/GROUP look-ahead groups, one pipeline stage per group. The group carry-out is registered into the next stage, and the upper operand groups are skewed through registers.
- Valid/ready handshake on input and output, with backpressure, add/subtract mode, and carry-out and signed-overflow flags.
- Used wherever the datapath needs wide sums at full throughput without one long combinational carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of GROUP.
- GROUP, 4, bits per look-ahead group; must be >= 1 and <= WIDTH.
- NUM_GROUPS, WIDTH/GROUP, derived (localparam), equals the pipeline depth and latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/mode valid this cycle
- in_ready  out  1  block accepts an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst high at a clk edge):
  - All stage valid bits cleared; out_valid=0; sum=0; cout=0; ovf=0.
  - In-flight operations are discarded, whatever state they are in.
- Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - When adv=0, every stage register holds its value; no data is lost or duplicated.
- Acceptance: in_valid & in_ready at an edge loads stage 0.
  - in_valid=0 while adv=1 loads a bubble (stage-0 valid=0).
- Stage k (0..NUM_GROUPS-1):
  - Computes group k sum bits from a[k], b'[k] and the incoming carry c_k, using generate/propagate look-ahead inside the group (no ripple between bits).
  - Registers the group sum, the group carry-out c_{k+1}, all lower sum bits already produced, the remaining upper operand groups, and the valid bit.
  - c_0 = sub ? 1 : cin; b' = sub ? ~b : b.
- Last stage additionally registers:
  - carry into the MSB, to form ovf;
  - cout = c_NUM_GROUPS.
- Latency and throughput:
  - Operation accepted in cycle 0 has out_valid=1 in cycle NUM_GROUPS, absent stalls. Each stall cycle adds one cycle.
  - Throughput 1 op/cycle with out_ready held high.
- Ordering: results emerge strictly in acceptance order.
- out_valid/sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Widths: sum is mod 2^WIDTH; no output wider than WIDTH+2 flags.
- NUM_GROUPS=1 (GROUP=WIDTH) is legal: single registered stage, latency 1.
- Elaboration must fail if WIDTH % GROUP != 0 or GROUP < 1.
- Simultaneous output handshake and new input: both happen in the same cycle. Bubbles are not collapsed; stall is global.
- rst asserted together with in_valid: the input is not accepted. in_ready may be 1 during reset but acceptance is suppressed.

Test Plan (WIDTH=16, GROUP=4 unless stated):
- a=0xFFFF, b=0x0001, cin=0, sub=0, accepted cycle 0, out_ready=1 -> cycle 4: out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x0FFF, cin=1 -> sum=0x2234, cout=0, ovf=0.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Back-to-back stream of 6 ops (a=i, b=0x0100*i, i=1..6):
  - Drop out_ready for 3 cycles once the first result appears -> in_ready=0 during the stall, outputs held stable.
  - All 6 results arrive in order, none lost or duplicated, total 6+4+3 cycles.
- Pipeline filled with 3 ops, rst pulsed 1 cycle -> next cycle out_valid=0, sum=0. No stale results appear afterwards. An op accepted after reset returns correctly after 4 cycles.
- WIDTH=8, GROUP=8: 1000 random ops with random in_valid/out_ready -> latency 1 when unstalled. Every result matches a reference model (a+b+cin or a-b) for sum, cout and ovf.
